// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count bit positions 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// Combinational 1-bit full adder, time-shared across all bit positions.
module serial_bit_slice (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  assign sum      = a ^ b ^ carryin;
  assign carryout = (a & b) | (carryin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice, LSB first,
// WIDTH cycles per operation, registered result and ALU flags.
// Optional macro SERIAL_ADDSUB_FLAGS_EN enables overflow/negative/zero;
// when undefined those ports are tied to 0.
module serial_addsub_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] partial_d;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             carryout_q;
  logic             slice_sum;
  logic             slice_co;
  logic             last_bit;

  serial_bit_slice u_slice (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .carryin  (carry_q),
    .sum      (slice_sum),
    .carryout (slice_co)
  );

  // Partial sum after this cycle's bit enters at the MSB end.
  assign partial_d = {slice_sum, partial_q[WIDTH-1:1]};
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  // Control FSM and serial datapath; subtraction is A + ~B + 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      partial_q  <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      carryout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            a_q       <= a;
            b_q       <= (op_sub == OP_SUB) ? ~b : b;
            carry_q   <= (op_sub == OP_ADD) ? 1'b0 : 1'b1;
            cnt_q     <= '0;
            partial_q <= '0;
          end
        end
        RUN: begin
          a_q       <= a_q >> 1;
          b_q       <= b_q >> 1;
          carry_q   <= slice_co;
          partial_q <= partial_d;
          cnt_q     <= cnt_q + CW'(1);
          if (last_bit) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            result_q   <= partial_d;
            carryout_q <= slice_co;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carryout = carryout_q;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic overflow_q;
  logic negative_q;
  logic zero_q;

  // Flags captured on the final bit; carry_q is the carry into the MSB slice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if ((state_q == RUN) && last_bit) begin
      overflow_q <= carry_q ^ slice_co;
      negative_q <= partial_d[WIDTH-1];
      zero_q     <= (partial_d == '0);
    end
  end

  assign overflow = overflow_q;
  assign negative = negative_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign negative = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8) with a plain
// arithmetic reference model; honours SERIAL_ADDSUB_FLAGS_EN like the DUT.
module tb_serial_addsub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         negative;
  logic         zero;

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow),
    .negative (negative),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                       output logic [W-1:0] r, output logic co, output logic ov,
                       output logic ng, output logic zr);
    int ua, ub, sa, sb, us, ss;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      co = (ua >= ub);
    end else begin
      us = ua + ub;
      ss = sa + sb;
      co = (us >= 256);
    end
    r = W'(us);
`ifdef SERIAL_ADDSUB_FLAGS_EN
    ov = (ss > 127) || (ss < -128);
    ng = r[W-1];
    zr = (r == '0);
`else
    ov = 1'b0;
    ng = 1'b0;
    zr = 1'b0;
`endif
  endtask

  // mode 0: plain op; 1: start re-asserted through RUN; 2: start asserted in DONE.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                       input int mode);
    logic [W-1:0] er;
    logic eco, eov, eng, ezr;
    int k;
    model(av, bv, sub, er, eco, eov, eng, ezr);
    @(negedge clk);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    @(negedge clk);
    check("busy_on_accept", busy, 1);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    k = 0;
    while (!done && k < 40) begin
      if (mode == 1) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      end
      @(negedge clk);
      k++;
      if (mode == 1) check("busy_in_run", busy, 1);
    end
    check("done_seen", done, 1);
    if (done) begin
      start = (mode == 2);
      if (mode == 2) begin
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      end
      check("latency", k + 1, W + 1);
      check("busy_in_done", busy, 1);
      check("result", result, er);
      check("carryout", carryout, eco);
      check("overflow", overflow, eov);
      check("negative", negative, eng);
      check("zero", zero, ezr);
      @(negedge clk);
      start = 1'b0;
      check("single_done", done, 0);
      check("busy_idle", busy, 0);
      check("result_hold", result, er);
      if (mode != 0) begin
        @(negedge clk);
        check("no_queued_op", busy, 0);
      end
    end
  endtask

  initial begin
    start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carryout", carryout, 0);
    check("rst_flags", {overflow, negative, zero}, 0);
    reset_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 0);
    do_op(8'h05, 8'h05, 1'b1, 0);
    do_op(8'h03, 8'h05, 1'b1, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h80, 8'h01, 1'b1, 0);
    do_op(8'h12, 8'h34, 1'b0, 1);
    do_op(8'h9C, 8'h21, 1'b1, 2);

    // Reset in the middle of RUN.
    do_op(8'h5A, 8'h33, 1'b0, 0);
    @(negedge clk);
    a = 8'h11; b = 8'h22; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_carryout", carryout, 0);
    check("midrst_flags", {overflow, negative, zero}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
      if (i == 2) reset_n = 1'b1;
    end
    do_op(8'h7F, 8'h01, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
